// File: rtl/fft32_out_reorder.sv
// Output reorder buffer for the 32-pt radix-4/4/2 MDC FFT: digit-reversed beats in, natural order out.
// Optional status outputs (ovf_o, frame_cnt_o) are enabled by defining FFT_REORDER_STATUS_EN.
`ifndef SFP_WIDTH
`define SFP_WIDTH 16
`endif

module fft32_out_reorder #(
  parameter int unsigned DW = `SFP_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sop_i,
  input  logic                valid_i,
  input  logic [4*DW-1:0]     dr_i,
  input  logic [4*DW-1:0]     di_i,
  output logic [4*DW-1:0]     dr_o,
  output logic [4*DW-1:0]     di_o,
  output logic                valid_o,
  output logic                sop_o,
  output logic                eop_o
`ifdef FFT_REORDER_STATUS_EN
  ,
  output logic                ovf_o,
  output logic [15:0]         frame_cnt_o
`endif
);

  localparam int unsigned LANES = 4;
  localparam int unsigned BINS  = 32;
  localparam int unsigned BUSW  = LANES * DW;

  typedef enum logic {W_IDLE, W_FILL}  wstate_e;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_e;

  wstate_e             wstate_q, wstate_d;
  rstate_e             rstate_q, rstate_d;
  logic [2:0]          wcnt_q, wcnt_d;
  logic [2:0]          rcnt_q, rcnt_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          full_q, full_d;
  logic                wr_en_c, set_full_c, rd_en_c, clr_full_c;
  logic [2:0]          wr_beat_c, rd_beat_c;
  logic [BUSW-1:0]     dr_q, dr_d, di_q, di_d;
  logic                valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;

  logic [DW-1:0]       mem_re_q [2][BINS];
  logic [DW-1:0]       mem_im_q [2][BINS];

  // Write side: tracks beat position within the incoming frame
  always_comb begin
    wstate_d   = wstate_q;
    wcnt_d     = wcnt_q;
    wr_bank_d  = wr_bank_q;
    wr_en_c    = 1'b0;
    set_full_c = 1'b0;
    wr_beat_c  = wcnt_q;
    unique case (wstate_q)
      W_IDLE: begin
        // A frame aimed at a still-full bank is discarded outright
        if (valid_i && sop_i && !full_q[wr_bank_q]) begin
          wr_en_c   = 1'b1;
          wr_beat_c = 3'd0;
          wcnt_d    = 3'd1;
          wstate_d  = W_FILL;
        end
      end
      W_FILL: begin
        if (valid_i) begin
          wr_en_c = 1'b1;
          if (sop_i) begin
            wr_beat_c = 3'd0;
            wcnt_d    = 3'd1;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == 3'd7) begin
              set_full_c = 1'b1;
              wr_bank_d  = ~wr_bank_q;
              wstate_d   = W_IDLE;
            end
          end
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read side plus registered output stage
  always_comb begin
    rstate_d   = rstate_q;
    rcnt_d     = rcnt_q;
    rd_bank_d  = rd_bank_q;
    rd_en_c    = 1'b0;
    clr_full_c = 1'b0;
    rd_beat_c  = rcnt_q;
    dr_d       = dr_q;
    di_d       = di_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_en_c   = 1'b1;
          rd_beat_c = 3'd0;
          rcnt_d    = 3'd1;
          rstate_d  = R_DRAIN;
        end
      end
      R_DRAIN: begin
        rd_en_c = 1'b1;
        rcnt_d  = rcnt_q + 3'd1;
        if (rcnt_q == 3'd7) begin
          clr_full_c = 1'b1;
          rd_bank_d  = ~rd_bank_q;
          rstate_d   = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    valid_d = rd_en_c;
    sop_d   = rd_en_c && (rd_beat_c == 3'd0);
    eop_d   = rd_en_c && (rd_beat_c == 3'd7);
    if (rd_en_c) begin
      for (int m = 0; m < LANES; m++) begin
        dr_d[DW*m +: DW] = mem_re_q[rd_bank_q][{rd_beat_c, 2'(m)}];
        di_d[DW*m +: DW] = mem_im_q[rd_bank_q][{rd_beat_c, 2'(m)}];
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (set_full_c) full_d[wr_bank_q] = 1'b1;
    if (clr_full_c) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      wcnt_q    <= 3'd0;
      rcnt_q    <= 3'd0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      dr_q      <= '0;
      di_q      <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      dr_q      <= dr_d;
      di_q      <= di_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
    end
  end

  // Bin storage, written at the digit-reversed bin index {b0,l1,l0,b2,b1}
  always_ff @(posedge clk_i) begin
    if (wr_en_c) begin
      for (int l = 0; l < LANES; l++) begin
        mem_re_q[wr_bank_q][{wr_beat_c[0], 2'(l), wr_beat_c[2:1]}] <= dr_i[DW*l +: DW];
        mem_im_q[wr_bank_q][{wr_beat_c[0], 2'(l), wr_beat_c[2:1]}] <= di_i[DW*l +: DW];
      end
    end
  end

  assign dr_o    = dr_q;
  assign di_o    = di_q;
  assign valid_o = valid_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;

`ifdef FFT_REORDER_STATUS_EN
  logic        drop_c;
  logic        ovf_q, ovf_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Dropped beats: sop restart mid-frame, or sop toward a full bank
  assign drop_c = valid_i && sop_i && ((wstate_q == W_FILL) || full_q[wr_bank_q]);

  always_comb begin
    ovf_d       = ovf_q | drop_c;
    frame_cnt_d = eop_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ovf_o       = ovf_q;
  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
